// File: rtl/uncached_axi_master.sv
// Single-beat AXI4 initiator for uncached MMIO loads/stores: one transaction in flight, one response pulse.
// Optional per-phase handshake timeout is enabled by defining AXI_MASTER_TIMEOUT_EN.
module uncached_axi_master #(
  parameter int WIDTH_ID       = 2,
  parameter int WIDTH_DA       = 32,
  parameter int WIDTH_AD       = 32,
  parameter int MST_ID         = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESETN,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [WIDTH_AD-1:0] core_addr_i,
  input  logic [WIDTH_DA-1:0] core_wdata_i,
  input  logic [3:0]          core_wstrb_i,
  output logic                core_ready_o,
  output logic                core_rvalid_o,
  output logic [WIDTH_DA-1:0] core_rdata_o,
  output logic                core_err_o,
  output logic [WIDTH_ID-1:0] M_AXI_AWID,
  output logic [WIDTH_AD-1:0] M_AXI_AWADDR,
  output logic [3:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [WIDTH_DA-1:0] M_AXI_WDATA,
  output logic [3:0]          M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [WIDTH_ID-1:0] M_AXI_BID,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [WIDTH_ID-1:0] M_AXI_ARID,
  output logic [WIDTH_AD-1:0] M_AXI_ARADDR,
  output logic [3:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [WIDTH_ID-1:0] M_AXI_RID,
  input  logic [WIDTH_DA-1:0] M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RLAST,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH_AD-1:0] addr_q, addr_d;
  logic [WIDTH_DA-1:0] wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [WIDTH_DA-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rvalid_q, rvalid_d;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Response identifiers and the low RESP bit carry no information for a single-master, single-beat path.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_BID, M_AXI_RID, M_AXI_RLAST, M_AXI_BRESP[0], M_AXI_RRESP[0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (core_req_i) begin
          addr_d  = core_addr_i;
          wdata_d = core_wdata_i;
          wstrb_d = core_wstrb_i;
          state_d = core_we_i ? S_AW : S_AR;
        end
      end
      S_AW: if (M_AXI_AWREADY) state_d = S_W;
      S_W:  if (M_AXI_WREADY)  state_d = S_B;
      S_B: begin
        if (M_AXI_BVALID) begin
          rdata_d = '0;
          err_d   = M_AXI_BRESP[1];
          state_d = S_RSP;
        end
      end
      S_AR: if (M_AXI_ARREADY) state_d = S_R;
      S_R: begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          err_d   = M_AXI_RRESP[1];
          state_d = S_RSP;
        end
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef AXI_MASTER_TIMEOUT_EN
    // The counter restarts on every state change, so each handshake phase gets its own budget.
    cnt_d = '0;
    if ((state_d == state_q) && (state_q inside {S_AW, S_W, S_B, S_AR, S_R})) begin
      if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_RSP;
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif

    // Handshake outputs are registered from the next state so they never depend on READY combinationally.
    awvalid_d = (state_d == S_AW);
    wvalid_d  = (state_d == S_W);
    bready_d  = (state_d == S_B);
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    rvalid_d  = (state_d == S_RSP);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rvalid_q  <= rvalid_d;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end
`endif

  assign core_ready_o  = (state_q == S_IDLE);
  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_err_o    = err_q;

  assign M_AXI_AWID    = WIDTH_ID'(MST_ID);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 4'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARID    = WIDTH_ID'(MST_ID);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARLEN   = 4'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_uncached_axi_master.sv
// Directed bench for uncached_axi_master: configurable-latency AXI slave, transaction-level response model,
// per-cycle channel checker, and literal expectations for the documented latencies and responses.
module tb_uncached_axi_master;
  localparam int T = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_i = 1'b0, core_we_i = 1'b0;
  logic [31:0] core_addr_i = '0, core_wdata_i = '0;
  logic [3:0]  core_wstrb_i = '0;
  logic        core_ready_o, core_rvalid_o, core_err_o;
  logic [31:0] core_rdata_o;
  logic [1:0]  awid, arid;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  uncached_axi_master #(.TIMEOUT_CYCLES(T)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_wstrb_i(core_wstrb_i), .core_ready_o(core_ready_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready), .M_AXI_BID(2'd0), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready), .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen),
    .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready), .M_AXI_RID(2'd0), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RLAST(1'b1), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  int vec = 0, bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave knobs: delays count cycles of VALID (or READY for B/R) before the slave answers.
  int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
  int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
  logic [1:0]  bresp_k = '0, rresp_k = '0;
  logic [31:0] rdata_k = '0;
  logic        unsol = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_awv;
    int          acc;
  } txn_t;
  txn_t q[$];

  logic        aw_done = 1'b0, chk_b2b = 1'b0;
  int          awv_cnt = 0, rv_count = 0, last_rv_cyc = 0, last_lat = 0, last_awv = 0;
  logic [31:0] last_rdata = '0, last_exp_rdata = '0;
  logic        last_err = 1'b0;

  function automatic txn_t predict(input logic we, input logic [31:0] a, d, input logic [3:0] s);
    txn_t t;
    logic tmo;
    t.we = we; t.addr = a; t.wdata = d; t.wstrb = s; t.acc = 0;
    t.exp_awv = aw_d + 1;
    tmo = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
    tmo = we ? (aw_d >= T || w_d >= T || b_d >= T) : (ar_d >= T || r_d >= T);
`endif
    if (tmo) begin
      t.exp_rdata = '0; t.exp_err = 1'b1; t.exp_lat = -1;
    end else if (we) begin
      t.exp_rdata = '0; t.exp_err = bresp_k[1]; t.exp_lat = 4 + aw_d + w_d + b_d;
    end else begin
      t.exp_rdata = rdata_k; t.exp_err = rresp_k[1]; t.exp_lat = 3 + ar_d + r_d;
    end
    return t;
  endfunction

  // Slave responses for the coming edge, then the per-cycle channel/response checker.
  always @(negedge clk) begin
    txn_t t;
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      q.delete(); aw_done = 0; awv_cnt = 0;
    end else begin
      if (awvalid) begin awready = (aw_c >= aw_d); aw_c++; end else begin awready = 0; aw_c = 0; end
      if (wvalid)  begin wready  = (w_c >= w_d);   w_c++;  end else begin wready  = 0; w_c = 0;  end
      if (arvalid) begin arready = (ar_c >= ar_d); ar_c++; end else begin arready = 0; ar_c = 0; end
      if (bready)  begin bvalid  = (b_c >= b_d);   b_c++;  end else begin bvalid  = unsol; b_c = 0; end
      if (rready)  begin rvalid  = (r_c >= r_d);   r_c++;  end else begin rvalid  = unsol; r_c = 0; end
      bresp = bresp_k; rresp = rresp_k; rdata = rdata_k;

      if (q.size() != 0) chk("ready_while_busy", 32'(core_ready_o), 32'd0);
      if (core_req_i && core_ready_o) begin
        t = predict(core_we_i, core_addr_i, core_wdata_i, core_wstrb_i);
        t.acc = cyc;
        if (chk_b2b) chk("b2b_accept_cycle", 32'(cyc), 32'(last_rv_cyc + 1));
        q.push_back(t);
        aw_done = 0; awv_cnt = 0;
      end
      if (awvalid) begin
        awv_cnt++;
        if (q.size() == 0) chk("aw_without_request", 32'(awvalid), 32'd0);
        else begin
          chk("aw_for_store", 32'(q[0].we), 32'd1);
          chk("awaddr", awaddr, q[0].addr);
          chk("aw_ctl", {21'd0, awid, awlen, awsize, awburst}, {21'd0, 2'd0, 4'd0, 3'b010, 2'b01});
        end
      end
      if (wvalid) begin
        chk("w_after_aw", 32'(aw_done), 32'd1);
        if (q.size() != 0) begin
          chk("wdata", wdata, q[0].wdata);
          chk("wstrb_wlast", {27'd0, wstrb, wlast}, {27'd0, q[0].wstrb, 1'b1});
        end
      end
      if (awvalid && awready) aw_done = 1;
      if (arvalid) begin
        if (q.size() == 0) chk("ar_without_request", 32'(arvalid), 32'd0);
        else begin
          chk("ar_for_load", 32'(q[0].we), 32'd0);
          chk("araddr", araddr, q[0].addr);
          chk("ar_ctl", {21'd0, arid, arlen, arsize, arburst}, {21'd0, 2'd0, 4'd0, 3'b010, 2'b01});
        end
      end
      if (core_rvalid_o) begin
        if (q.size() == 0) chk("rvalid_unexpected", 32'(core_rvalid_o), 32'd0);
        else begin
          t = q.pop_front();
          chk("rsp_rdata", core_rdata_o, t.exp_rdata);
          chk("rsp_err", 32'(core_err_o), 32'(t.exp_err));
          if (t.exp_lat >= 0) begin
            chk("rsp_latency", 32'(cyc - t.acc), 32'(t.exp_lat));
            if (t.we) chk("awvalid_cycles", 32'(awv_cnt), 32'(t.exp_awv));
          end
          last_lat = cyc - t.acc; last_awv = awv_cnt; last_exp_rdata = t.exp_rdata;
        end
        last_rv_cyc = cyc; last_rdata = core_rdata_o; last_err = core_err_o;
        rv_count++;
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, d, input logic [3:0] s);
    bit ok = 0;
    @(posedge clk); #1;
    core_req_i = 1; core_we_i = we; core_addr_i = a; core_wdata_i = d; core_wstrb_i = s;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (core_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 32'(core_ready_o), 32'd1);
    @(posedge clk); #1;
    core_req_i = 0;
  endtask

  task automatic wait_rsp(input int target, input int limit);
    bit ok = 0;
    for (int n = 0; n < limit; n++) begin
      @(posedge clk);
      if (rv_count >= target) begin ok = 1; break; end
    end
    if (!ok) chk("response_timeout", 32'(rv_count), 32'(target));
  endtask

  initial begin
    int rc0;
    bit ok;
    #12;
    chk("reset_axi_handshakes", {26'd0, awvalid, wvalid, bready, arvalid, rready, core_rvalid_o}, 32'd0);
    chk("reset_rsp_payload", {31'd0, core_err_o} | core_rdata_o, 32'd0);
    chk("reset_aw_payload", awaddr | wdata | {28'd0, wstrb}, 32'd0);
    @(negedge clk); rst_n = 1;

    // Store 3 to 0x0, always-ready slave.
    issue(1, 32'h0000_0000, 32'h0000_0003, 4'hF);
    wait_rsp(1, 50);
    chk("store_latency_lit", 32'(last_lat), 32'd4);
    chk("store_err_lit", 32'(last_err), 32'd0);
    chk("store_rdata_lit", last_rdata, 32'd0);

    // Load 0x4 returning 0x2A.
    rdata_k = 32'h0000_002A;
    issue(0, 32'h0000_0004, 32'h0, 4'h0);
    wait_rsp(2, 50);
    chk("load_rdata_lit", last_rdata, 32'h0000_002A);
    chk("load_err_lit", 32'(last_err), 32'd0);
    chk("load_latency_lit", 32'(last_lat), 32'd3);

    // AWREADY held low for 5 cycles.
    aw_d = 5;
    issue(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3);
    wait_rsp(3, 60);
    chk("aw_stall_valid_lit", 32'(last_awv), 32'd6);
    chk("aw_stall_latency_lit", 32'(last_lat), 32'd9);
    aw_d = 0;

    // Error responses.
    rresp_k = 2'b10; rdata_k = 32'h1234_5678;
    issue(0, 32'h0000_0008, 32'h0, 4'h0);
    wait_rsp(4, 50);
    chk("slverr_load_err_lit", 32'(last_err), 32'd1);
    chk("slverr_load_rdata_lit", last_rdata, 32'h1234_5678);
    rresp_k = 2'b00;
    bresp_k = 2'b11; w_d = 2; b_d = 1;
    issue(1, 32'h4000_0020, 32'hA5A5_0F0F, 4'hC);
    wait_rsp(5, 60);
    chk("decerr_store_err_lit", 32'(last_err), 32'd1);
    bresp_k = 2'b00; w_d = 0; b_d = 0;

    // Slow read path, then check the response fields hold.
    ar_d = 2; r_d = 3; rdata_k = 32'hCAFE_0001;
    issue(0, 32'h8000_0100, 32'h0, 4'h0);
    wait_rsp(6, 60);
    ar_d = 0; r_d = 0;
    repeat (3) @(posedge clk);
    #1 chk("rdata_hold", core_rdata_o, last_exp_rdata);

    // Back-to-back: load then store with req held high.
    rdata_k = 32'h0000_0077;
    @(posedge clk); #1;
    core_req_i = 1; core_we_i = 0; core_addr_i = 32'h0000_000C;
    @(posedge clk); #1;
    core_we_i = 1; core_addr_i = 32'h0000_0030; core_wdata_i = 32'h5555_AAAA; core_wstrb_i = 4'hF;
    chk_b2b = 1;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (core_ready_o) begin ok = 1; break; end
    end
    if (!ok) chk("b2b_second_accept", 32'(core_ready_o), 32'd1);
    @(posedge clk); #1;
    core_req_i = 0; chk_b2b = 0;
    wait_rsp(8, 60);

    // Unsolicited BVALID/RVALID while idle.
    unsol = 1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("unsolicited_ready", {30'd0, bready, rready}, 32'd0);
    end
    unsol = 0;
    repeat (2) @(posedge clk);
    chk("unsolicited_no_rsp", 32'(rv_count), 32'd8);

    // Reset while waiting in B.
    b_d = 100;
    issue(1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bready) begin ok = 1; break; end
    end
    if (!ok) chk("reach_b_state", 32'(bready), 32'd1);
    #2 rst_n = 0;
    #1 chk("reset_in_b_outputs", {26'd0, awvalid, wvalid, bready, arvalid, rready, core_rvalid_o}, 32'd0);
    rc0 = rv_count;
    b_d = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    repeat (10) @(posedge clk);
    chk("reset_abort_no_rsp", 32'(rv_count), 32'(rc0));
    rdata_k = 32'h0000_0099;
    issue(0, 32'h0000_0044, 32'h0, 4'h0);
    wait_rsp(rc0 + 1, 50);
    chk("post_reset_load_lit", last_rdata, 32'h0000_0099);

`ifdef AXI_MASTER_TIMEOUT_EN
    ar_d = 1000;
    rc0 = rv_count;
    issue(0, 32'h0000_0050, 32'h0, 4'h0);
    wait_rsp(rc0 + 1, 200);
    chk("timeout_err_lit", 32'(last_err), 32'd1);
    chk("timeout_rdata_lit", last_rdata, 32'd0);
    chk("timeout_latency_lit", 32'(last_lat), 32'(T + 1));
    ar_d = 0;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
